dma_blk_reader: RTL
===================

# dma_blk_reader

AXI4 read master that fetches image/weight blocks from memory and streams them as 64-bit beats into the 112-bit row packer (`dma_pack_112`), directly upstream of it. Each block is `BEATS_PER_BLOCK` consecutive 8-byte beats (25 beats = 200 bytes, enough to cover one 14×14-byte block). Blocks are fetched back-to-back from a linear base address, with one outstanding burst at a time. The read-data channel is forwarded with a one-cycle register stage, and there is no backpressure toward the packer.

## Interface
Parameters:
- `ADDR_W`, 32 — AXI byte-address width
- `BEATS_PER_BLOCK`, 25 — beats per block (1..256)
- `NBLK_W`, 16 — width of block-count input

Ports:
- `clk`  in  1  — single clock
- `rst_n`  in  1  — asynchronous, active-low reset
- `start`  in  1  — 1-cycle pulse; accepted only in IDLE
- `base_addr`  in  ADDR_W  — byte address of block 0; bits [2:0] forced to 0 internally
- `num_blocks`  in  NBLK_W  — number of blocks to fetch
- `busy`  out  1  — high from accepted `start` until `done`
- `done`  out  1  — 1-cycle completion pulse
- `err`  out  1  — sticky; set on any RRESP≠OKAY or RLAST mismatch; cleared on accepted `start`
- `m_arvalid` out 1, `m_arready` in 1, `m_araddr` out ADDR_W, `m_arlen` out 8, `m_arsize` out 3 (constant 3'd3), `m_arburst` out 2 (constant 2'b01 INCR)
- `m_rvalid` in 1, `m_rready` out 1, `m_rdata` in 64, `m_rresp` in 2, `m_rlast` in 1
- `dma_we`  out  1  — beat valid to packer
- `dma_wdata`  out  64  — beat data to packer

## Operation
- States: IDLE → ADDR → DATA → (ADDR | FIN) → IDLE.
- IDLE: on `start`, latch `base_addr` (with [2:0] cleared) and `num_blocks`, clear `err`, and assert `busy`. If `num_blocks==0`, go to FIN and issue no AR. Otherwise set `blk_left=num_blocks` and `beats_left=BEATS_PER_BLOCK`, then go to ADDR.
- ADDR: drive `m_arvalid` and hold `m_araddr`/`m_arlen` stable until `m_arready`. Burst length is `burst = beats_left` (see Configuration for the 4 KB split), with `m_arlen = burst-1`. On handshake, go to DATA.
- DATA: `m_rready=1`. Each R handshake:
  - `dma_we` pulses next cycle with `dma_wdata` = the captured `m_rdata`;
  - `beats_left` and the burst counter decrement;
  - `m_rresp≠0` sets `err`;
  - `m_rlast` asserted on any beat other than the counted last beat of the burst, or deasserted on the counted last beat, sets `err`.
- The burst ends on the beat count, never on `m_rlast`.
- At burst end:
  - if `beats_left>0`, advance the address and go to ADDR;
  - else decrement `blk_left`; if it is still nonzero, the next block address is previous block start + 8·BEATS_PER_BLOCK, reload `beats_left`, go to ADDR; else go to FIN.
- FIN: pulse `done`, drop `busy`, go to IDLE.
- `start` while busy is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. An in-flight AXI burst is abandoned; the interconnect must also be reset.
- The packer's block structure is set by `BEATS_PER_BLOCK`. The packer auto-realigns after 14 rows, so the extra residue beat per block needs no handling here.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `m_arvalid=0`, `m_araddr=0`, `m_arlen=0`, `m_rready=0`, `dma_we=0`, `dma_wdata=0`.
- `start` at edge t → `m_arvalid` high at t+1 (or `done` at t+2 when `num_blocks==0`).
- R beat handshake at edge t → `dma_we` high during cycle t+1. Back-to-back beats give contiguous `dma_we`.
- After the AR handshake at edge t, the next ARVALID rises no earlier than one cycle after the final R beat of that burst. There is no AR/R overlap.
- `done` rises the cycle after the final `dma_we`, aligned with the packer's final `buf_we`.
- `m_rready` is low outside DATA.

## Configuration
- `DMA_RD_4K_SPLIT_EN` defined: `burst = min(beats_left, (4096 - addr[11:0])/8)`. A block crossing a 4 KB boundary is issued as two bursts, the second starting exactly at the boundary.
- Not defined: `burst = beats_left` always, one AR per block. Software guarantees that no block crosses 4 KB.

## Test plan
- `base_addr=0`, `num_blocks=1`, ARREADY/RVALID always high → one AR (addr 0x0, len 24), 25 contiguous `dma_we` with matching data, `done` one cycle after the last beat, `err=0`.
- `num_blocks=3` from 0x1000, random ARREADY/RVALID stalls → AR addrs 0x1000, 0x10C8, 0x1190, each len 24; 75 `dma_we` in order; packer downstream emits 42 rows that are byte-exact against memory.
- With `DMA_RD_4K_SPLIT_EN`, `base_addr=0xFA0`, 1 block → AR 0xFA0 len 11, then AR 0x1000 len 12. Without the macro → single AR 0xFA0 len 24.
- SLVERR on beat 5 of 25 → all 25 beats still forwarded, `err=1` at `done`. Next `start` clears `err`.
- `m_rlast` asserted on beat 10 of 25 → `err=1`, transfer still completes after 25 beats. Separately, `num_blocks=0` → no ARVALID and `done` 2 cycles after `start`.
- `rst_n` low during beat 12 → all outputs reach reset values asynchronously. A fresh `start` after release fetches correctly from the new base.

Source files
------------

// File: rtl/dma_blk_reader.sv
// AXI4 read master: fetches num_blocks blocks of BEATS_PER_BLOCK 64-bit beats and streams them out.
// Optional macro DMA_RD_4K_SPLIT_EN splits bursts at 4 KB boundaries.
module dma_blk_reader #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BEATS_PER_BLOCK = 25,
  parameter int unsigned NBLK_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              dma_we,
  output logic [63:0]       dma_wdata
);

  localparam logic [8:0]        BeatsInit = 9'(BEATS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BlkBytes  = ADDR_W'(8 * BEATS_PER_BLOCK);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   blk_addr_q, blk_addr_d;
  logic [NBLK_W-1:0]   blk_left_q, blk_left_d;
  logic [8:0]          beats_left_q, beats_left_d;
  logic [8:0]          burst_left_q, burst_left_d;
  logic [7:0]          arlen_q, arlen_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q;
  logic                we_q;
  logic [63:0]         wdata_q;
  logic [8:0]          cur_burst;
  logic [9:0]          burst_cap;
  logic [9:0]          burst;

  assign cur_burst = {1'b0, arlen_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    blk_addr_d   = blk_addr_q;
    blk_left_d   = blk_left_q;
    beats_left_d = beats_left_q;
    burst_left_d = burst_left_q;
    arlen_d      = arlen_q;
    err_d        = err_q;
    busy_d       = busy_q;
    burst_cap    = 10'd512;
    burst        = 10'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d       = 1'b1;
          err_d        = 1'b0;
          addr_d       = {base_addr[ADDR_W-1:3], 3'b000};
          blk_addr_d   = {base_addr[ADDR_W-1:3], 3'b000};
          blk_left_d   = num_blocks;
          beats_left_d = BeatsInit;
          state_d      = (num_blocks == '0) ? StFin : StAddr;
        end
      end
      StAddr: begin
        if (m_arready) begin
          burst_left_d = cur_burst;
          state_d      = StData;
        end
      end
      StData: begin
        if (m_rvalid) begin
          beats_left_d = beats_left_q - 9'd1;
          burst_left_d = burst_left_q - 9'd1;
          if (m_rresp != 2'b00) err_d = 1'b1;
          if (m_rlast != (burst_left_q == 9'd1)) err_d = 1'b1;
          // Burst ends on the beat count; RLAST is only checked, never trusted.
          if (burst_left_q == 9'd1) begin
            if (beats_left_q != 9'd1) begin
              addr_d  = addr_q + (ADDR_W'(cur_burst) << 3);
              state_d = StAddr;
            end else begin
              blk_left_d = blk_left_q - 1'b1;
              if (blk_left_q != NBLK_W'(1)) begin
                addr_d       = blk_addr_q + BlkBytes;
                blk_addr_d   = blk_addr_q + BlkBytes;
                beats_left_d = BeatsInit;
                state_d      = StAddr;
              end else begin
                state_d = StFin;
              end
            end
          end
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef DMA_RD_4K_SPLIT_EN
    burst_cap = 10'd512 - {1'b0, addr_d[11:3]};
`else
    burst_cap = 10'd512;
`endif
    burst = ({1'b0, beats_left_d} < burst_cap) ? {1'b0, beats_left_d} : burst_cap;
    // AR fields are computed once on entry to StAddr so they stay stable until ARREADY.
    if (state_d == StAddr && state_q != StAddr) arlen_d = 8'(burst - 10'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      blk_addr_q   <= '0;
      blk_left_q   <= '0;
      beats_left_q <= '0;
      burst_left_q <= '0;
      arlen_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      blk_addr_q   <= blk_addr_d;
      blk_left_q   <= blk_left_d;
      beats_left_q <= beats_left_d;
      burst_left_q <= burst_left_d;
      arlen_q      <= arlen_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= (state_q == StFin);
      we_q         <= (state_q == StData) && m_rvalid;
      if ((state_q == StData) && m_rvalid) wdata_q <= m_rdata;
    end
  end

  assign m_arvalid = (state_q == StAddr);
  assign m_araddr  = addr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = 3'd3;
  assign m_arburst = 2'b01;
  assign m_rready  = (state_q == StData);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dma_we    = we_q;
  assign dma_wdata = wdata_q;

endmodule
